seg7_scan_mux: RTL
==================

// Module: seg7_scan_mux
// PURPOSE
//  Time-multiplexed driver for the 8-digit common-anode 7-segment display.
//  - Consumes a packed bus of 4-bit hex values, e.g. adder sums; one value per digit.
//  - Scans the digits in turn and drives AN[7:0], CA..CG and DP directly.
//  - Lets the board show all digits instead of only AN[0].
//  - All display outputs are active-LOW and registered.
// PARAMETERS
//  NUM_DIGITS    8       digits scanned; also width of AN
//  TICK_DIV      100000  clocks per digit slot (1 kHz/digit, 125 Hz frame @100 MHz); >=2
//  BLANK_CYCLES  16      clocks at the start of each slot with all AN high (anti-ghost); < TICK_DIV
// PORTS
//  CLK100MHZ   in   1             system clock, rising edge
//  CPU_RESETN  in   1             asynchronous active-low reset
//  digits      in   4*NUM_DIGITS  hex value per digit; digit i = digits[4i+3:4i]
//  dig_en      in   NUM_DIGITS    1 = digit i may light; 0 = its AN stays high
//  dp_in       in   NUM_DIGITS    1 = decimal point lit on digit i
//  AN          out  NUM_DIGITS    anode selects, active-LOW
//  CA..CG      out  1 each        segments a..g, active-LOW
//  DP          out  1             decimal point, active-LOW
//  frame_start out  1             one-cycle pulse, high in the cycle after idx wraps to 0
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - Outputs: AN = all 1, CA..CG = 1, DP = 1, frame_start = 0.
//   - State: cnt = 0, idx = 0, snapshot = 0.
//  Prescaler: cnt counts 0..TICK_DIV-1 and then wraps to 0.
//   - On wrap, idx advances 0..NUM_DIGITS-1; NUM_DIGITS-1 wraps to 0.
//  Snapshot: digits/dig_en/dp_in are captured on the edge where idx wraps to 0.
//   - Capture happens once per frame, so a frame never tears.
//   - frame_start is high in the following cycle.
//   - Input changes mid-frame take effect only at the next frame.
//  Output stage, registered (one clock behind cnt/idx):
//   - cnt < BLANK_CYCLES: AN = all 1. Segments hold the new digit's pattern.
//   - else: AN[idx] = ~en_snap[idx]; all other AN bits = 1.
//   - CA..CG = ~seg(digit_snap[idx]), using the 0-F table in seg7_pkg.
//   - DP = ~dp_snap[idx].
//  Disabled digit: its slot still elapses; AN stays all 1, so scan timing is uniform.
//  Never more than one AN bit low in any cycle.
//  Reset mid-slot: all outputs go inactive immediately; scan restarts at digit 0, cnt 0.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//   - Blanks zero-valued digits from the highest enabled index down to the first
//     nonzero digit. Blanked digits drive CA..CG = 1 and DP = ~dp_snap[idx].
//   - Digit 0 is never blanked.
//   - Evaluated on the snapshot.
//  LEADING_ZERO_BLANK_EN undefined: all enabled digits show their value, zeros included.
// STRUCTURE
//  seg7_pkg:
//   - SEG_HEX[16] 7-bit active-HIGH patterns {g,f,e,d,c,b,a}.
//   - SEG_BLANK = 7'h00.
//  Sub-module hex7seg_decode: combinational 4-bit -> 7-bit active-HIGH lookup.
//   - Single instance after the idx mux.
//  Top: prescaler, idx counter, snapshot regs, blanking logic, output registers.
// TESTING (bench uses TICK_DIV=4, BLANK_CYCLES=1, NUM_DIGITS=8)
//  1 Reset: hold CPU_RESETN=0 for 5 clks.
//    -> AN=8'hFF, CA..CG=1, DP=1, frame_start=0.
//    -> After release, first AN=8'hFE appears 2 clks after release (slot 0, cnt=1, +1 reg).
//  2 Scan order: digits=32'h76543210, dig_en=8'hFF, dp_in=8'h00.
//    -> AN low bit walks 0..7, 3 clks low + 1 clk all-high per slot.
//    -> Segments match SEG_HEX[i] in slot i; frame_start every 32 clks.
//  3 Snapshot: change digits to 32'hFFFFFFFF mid-frame.
//    -> Remaining slots of that frame still show the old values.
//    -> New values appear from the slot after the next frame_start.
//  4 Enable/DP masks: dig_en=8'h05, dp_in=8'h04.
//    -> AN low only in slots 0 and 2.
//    -> DP=0 only in slot 2.
//    -> Never two AN bits low at once (assertion).
//  5 Reset mid-slot: assert CPU_RESETN=0 during slot 5.
//    -> Same cycle: AN=8'hFF, segments=1.
//    -> After release, scan resumes at digit 0.
//  6 LEADING_ZERO_BLANK_EN: digits=32'h00000A00, dig_en=8'hFF.
//    -> Slots 7..3 segments = 1; slot 2 shows A; slots 1,0 show 0.
//    -> With digits=0, only slot 0 shows 0.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seg7_pkg                                                      |
// | Purpose  : Shared constants for the 7-segment scan driver: the 0-F       |
// |            glyph table (active-HIGH, bit order {g,f,e,d,c,b,a}) and the  |
// |            all-segments-off pattern.                                     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package seg7_pkg;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F,  // 0
        7'h06,  // 1
        7'h5B,  // 2
        7'h4F,  // 3
        7'h66,  // 4
        7'h6D,  // 5
        7'h7D,  // 6
        7'h07,  // 7
        7'h7F,  // 8
        7'h6F,  // 9
        7'h77,  // A
        7'h7C,  // b
        7'h39,  // C
        7'h5E,  // d
        7'h79,  // E
        7'h71   // F
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/hex7seg_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hex7seg_decode                                                |
// | Purpose  : Combinational 4-bit hex to 7-segment lookup (active-HIGH).    |
// | Ports    : i_hex [3:0]  hex nibble to display                            |
// |            o_seg [6:0]  segment pattern {g,f,e,d,c,b,a}, 1 = lit         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module hex7seg_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_HEX[i_hex];

endmodule : hex7seg_decode
`default_nettype wire

// File: rtl/seg7_scan_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seg7_scan_mux                                                 |
// | Purpose  : Time-multiplexed driver for a common-anode multi-digit        |
// |            7-segment display. A prescaler divides each digit slot into   |
// |            TICK_DIV clocks; the first BLANK_CYCLES of every slot keep    |
// |            all anodes off to suppress ghosting. Inputs are snapshotted   |
// |            once per frame so a frame never shows mixed data.             |
// | Ports    : CLK100MHZ   in  system clock                                  |
// |            CPU_RESETN  in  asynchronous active-low reset                 |
// |            digits      in  packed hex values, digit i = [4i+3:4i]        |
// |            dig_en      in  per-digit enable                              |
// |            dp_in       in  per-digit decimal point                       |
// |            AN          out anode selects, active-LOW                     |
// |            CA..CG      out segments a..g, active-LOW                     |
// |            DP          out decimal point, active-LOW                     |
// |            frame_start out one-cycle pulse after the scan wraps to 0     |
// | Options  : LEADING_ZERO_BLANK_EN - blank leading zero digits             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    CLK100MHZ,
    input  logic                    CPU_RESETN,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic                    CA,
    output logic                    CB,
    output logic                    CC,
    output logic                    CD,
    output logic                    CE,
    output logic                    CF,
    output logic                    CG,
    output logic                    DP,
    output logic                    frame_start
);

    localparam int c_CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TICK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK   = c_CNT_W'(BLANK_CYCLES);
    localparam logic [c_IDX_W-1:0] c_IDX_MAX = c_IDX_W'(NUM_DIGITS - 1);

    // ------------------------------------------------------------------
    // Prescaler and digit index
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_IDX_W-1:0] r_idx;
    logic               w_cnt_wrap;
    logic               w_idx_wrap;

    assign w_cnt_wrap = (r_cnt == c_CNT_MAX);
    assign w_idx_wrap = w_cnt_wrap && (r_idx == c_IDX_MAX);

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_cnt_wrap) begin
            r_cnt <= '0;
            r_idx <= (r_idx == c_IDX_MAX) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame snapshot
    // The scan leaves reset already sitting at digit 0, which is the start
    // of a frame, so the inputs are also captured on the first clock after
    // reset release. Without this the whole first frame would be dark.
    // ------------------------------------------------------------------
    logic                         r_first_cycle;
    logic [NUM_DIGITS-1:0][3:0]   r_digit_snap;
    logic [NUM_DIGITS-1:0]        r_en_snap;
    logic [NUM_DIGITS-1:0]        r_dp_snap;
    logic                         w_capture;

    assign w_capture = w_idx_wrap || r_first_cycle;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_first_cycle <= 1'b1;
            r_digit_snap  <= '0;
            r_en_snap     <= '0;
            r_dp_snap     <= '0;
        end else begin
            r_first_cycle <= 1'b0;
            if (w_capture) begin
                r_digit_snap <= digits;
                r_en_snap    <= dig_en;
                r_dp_snap    <= dp_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero blanking, evaluated on the snapshot
    // ------------------------------------------------------------------
    logic w_blank_sel;

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] w_lead_blank;

    // Walk from the top digit down; disabled digits are skipped so they
    // neither start nor end the run of leading zeros. Digit 0 is excluded
    // so a zero value still shows a single 0.
    always_comb begin : lzb_scan
        logic w_zero_run;
        w_lead_blank = '0;
        w_zero_run   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (r_en_snap[i]) begin
                if (w_zero_run && (r_digit_snap[i] == 4'h0)) begin
                    w_lead_blank[i] = 1'b1;
                end else begin
                    w_zero_run = 1'b0;
                end
            end
        end
    end

    assign w_blank_sel = w_lead_blank[r_idx];
`else
    assign w_blank_sel = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Digit mux and decode (single decoder after the mux)
    // ------------------------------------------------------------------
    logic [3:0] w_digit_sel;
    logic [6:0] w_seg_hex;
    logic [6:0] w_seg_next;

    assign w_digit_sel = r_digit_snap[r_idx];

    hex7seg_decode u_decode (
        .i_hex (w_digit_sel),
        .o_seg (w_seg_hex)
    );

    assign w_seg_next = w_blank_sel ? SEG_BLANK : w_seg_hex;

    // At most one anode bit is ever cleared, and only outside the
    // anti-ghost window of the slot.
    logic [NUM_DIGITS-1:0] w_an_next;

    always_comb begin
        w_an_next = '1;
        if ((r_cnt >= c_BLANK) && r_en_snap[r_idx]) begin
            w_an_next[r_idx] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registered, active-LOW output stage
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg_n;
    logic                  r_dp_n;
    logic                  r_frame_start;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_an          <= '1;
            r_seg_n       <= 7'h7F;
            r_dp_n        <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_an          <= w_an_next;
            r_seg_n       <= ~w_seg_next;
            r_dp_n        <= ~r_dp_snap[r_idx];
            r_frame_start <= w_idx_wrap;
        end
    end

    assign AN          = r_an;
    assign CA          = r_seg_n[0];
    assign CB          = r_seg_n[1];
    assign CC          = r_seg_n[2];
    assign CD          = r_seg_n[3];
    assign CE          = r_seg_n[4];
    assign CF          = r_seg_n[5];
    assign CG          = r_seg_n[6];
    assign DP          = r_dp_n;
    assign frame_start = r_frame_start;

endmodule : seg7_scan_mux
`default_nettype wire
